// File: rtl/mips_pkg.sv
// Shared MIPS core constants: HALT/bubble instruction words and the IF/ID stage state encoding.
package mips_pkg;

  localparam int unsigned WORD_BITS = 32;

  localparam logic [WORD_BITS-1:0] HALT_OPCODE = 32'hFFFF_FFFF;
  localparam logic [WORD_BITS-1:0] NOP         = 32'h0000_0000;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } ifid_state_e;

endpackage

// File: rtl/step_ctrl.sv
// Debug single-step gating: registers the step request and remembers a step edge
// until an advance actually consumes it.
module step_ctrl (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic step_mode,
  input  logic step,
  input  logic consume,
  output logic step_ok
);

  logic step_q;
  logic step_pend;
  logic step_pend_d;
  logic step_rise;

  assign step_rise = step & ~step_q;
  assign step_ok   = ~step_mode | step_pend | step_rise;

  // Leaving step mode drops any pending step; an edge that is not consumed this cycle is kept.
  always_comb begin
    step_pend_d = step_pend;
    if (!step_mode || consume) begin
      step_pend_d = 1'b0;
    end else if (run && step_rise) begin
      step_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q    <= 1'b0;
      step_pend <= 1'b0;
    end else begin
      step_q    <= step;
      step_pend <= step_pend_d;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: captures instruction and PC+4/PC+8, injects bubbles on flush,
// honours stalls and debug single-step, detects HALT and drives the PC write enable.
module if_id_stage #(
  parameter int unsigned              NBITS       = 32,
  parameter int unsigned              CNTBITS     = 16,
  parameter logic [NBITS-1:0]         HALT_OPCODE = NBITS'(mips_pkg::HALT_OPCODE),
  parameter logic [NBITS-1:0]         NOP         = NBITS'(mips_pkg::NOP)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NBITS-1:0]   i_PC_4,
  input  logic [NBITS-1:0]   i_PC_8,
  input  logic [NBITS-1:0]   i_Instr,
  input  logic               i_Stall,
  input  logic               i_Flush,
  input  logic               i_StepMode,
  input  logic               i_Step,
  output logic [NBITS-1:0]   o_PC_4,
  output logic [NBITS-1:0]   o_PC_8,
  output logic [NBITS-1:0]   o_Instr,
  output logic               o_Valid,
  output logic               o_PC_Write,
  output logic               o_Halt,
  output logic [CNTBITS-1:0] o_InstrCount
);

  mips_pkg::ifid_state_e state_q, state_d;

  logic [NBITS-1:0]   pc4_d, pc8_d, instr_d;
  logic               valid_d, halt_d;
  logic [CNTBITS-1:0] cnt_d;
  logic               run, step_ok, adv, consume, pc_write;

  assign run = (state_q == mips_pkg::ST_RUN);
  assign adv = run & ~i_Stall & step_ok;

  step_ctrl u_step_ctrl (
    .clk       (i_clk),
    .reset     (i_reset),
    .run       (run),
    .step_mode (i_StepMode),
    .step      (i_Step),
    .consume   (consume),
    .step_ok   (step_ok)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= mips_pkg::ST_RUN;
      o_PC_4       <= '0;
      o_PC_8       <= '0;
      o_Instr      <= NOP;
      o_Valid      <= 1'b0;
      o_Halt       <= 1'b0;
      o_InstrCount <= '0;
    end else begin
      state_q      <= state_d;
      o_PC_4       <= pc4_d;
      o_PC_8       <= pc8_d;
      o_Instr      <= instr_d;
      o_Valid      <= valid_d;
      o_Halt       <= halt_d;
      o_InstrCount <= cnt_d;
    end
  end

  // Flush beats stall/step/HALT; otherwise only an advance moves the stage.
  always_comb begin
    state_d  = state_q;
    pc4_d    = o_PC_4;
    pc8_d    = o_PC_8;
    instr_d  = o_Instr;
    valid_d  = o_Valid;
    halt_d   = o_Halt;
    cnt_d    = o_InstrCount;
    consume  = 1'b0;
    pc_write = 1'b0;

    case (state_q)
      mips_pkg::ST_RUN: begin
        if (i_Flush) begin
          pc4_d    = i_PC_4;
          pc8_d    = i_PC_8;
          instr_d  = NOP;
          valid_d  = 1'b0;
          pc_write = 1'b1;
        end else if (adv) begin
          consume = 1'b1;
          pc4_d   = i_PC_4;
          pc8_d   = i_PC_8;
          instr_d = i_Instr;
          valid_d = 1'b1;
          if (!(&o_InstrCount)) begin
            cnt_d = o_InstrCount + CNTBITS'(1);
          end
          if (i_Instr == HALT_OPCODE) begin
            state_d = mips_pkg::ST_HALTED;
            halt_d  = 1'b1;
          end else begin
            pc_write = 1'b1;
          end
        end
      end
      mips_pkg::ST_HALTED: begin
        instr_d = NOP;
        valid_d = 1'b0;
        halt_d  = 1'b1;
      end
      default: begin
        state_d = mips_pkg::ST_RUN;
      end
    endcase

    if (i_reset) begin
      pc_write = 1'b0;
      consume  = 1'b0;
    end
  end

  assign o_PC_Write = pc_write;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed vector table, counter saturation sequence and
// randomized traffic checked against a behavioural model.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, smode, step;
  logic [31:0] pc4, pc8, instr;

  logic [31:0] o_pc4, o_pc8, o_instr;
  logic        o_valid, o_pcw, o_halt;
  logic [15:0] o_cnt;

  logic [31:0] s_pc4, s_pc8, s_instr;
  logic        s_valid, s_pcw, s_halt;
  logic [3:0]  s_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  if_id_stage dut (
    .i_clk(clk), .i_reset(reset), .i_PC_4(pc4), .i_PC_8(pc8), .i_Instr(instr),
    .i_Stall(stall), .i_Flush(flush), .i_StepMode(smode), .i_Step(step),
    .o_PC_4(o_pc4), .o_PC_8(o_pc8), .o_Instr(o_instr), .o_Valid(o_valid),
    .o_PC_Write(o_pcw), .o_Halt(o_halt), .o_InstrCount(o_cnt)
  );

  if_id_stage #(.CNTBITS(4)) dut4 (
    .i_clk(clk), .i_reset(reset), .i_PC_4(pc4), .i_PC_8(pc8), .i_Instr(instr),
    .i_Stall(stall), .i_Flush(flush), .i_StepMode(smode), .i_Step(step),
    .o_PC_4(s_pc4), .o_PC_8(s_pc8), .o_Instr(s_instr), .o_Valid(s_valid),
    .o_PC_Write(s_pcw), .o_Halt(s_halt), .o_InstrCount(s_cnt)
  );

  typedef struct {
    bit          rst, stl, fl, sm, st;
    logic [31:0] in_pc4, in_instr;
    bit          e_pcw;
    logic [31:0] e_pc4, e_instr;
    bit          e_valid, e_halt;
    int          e_cnt;
  } vec_t;

  vec_t tv[$];

  // behavioural model state
  bit          m_halted, m_stepq, m_pend, m_valid, m_halt;
  logic [31:0] m_pc4, m_pc8, m_instr;
  int          m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rst, bit stl, bit fl, bit sm, bit st,
                              logic [31:0] ip, logic [31:0] ii, bit ew,
                              logic [31:0] ep, logic [31:0] ei, bit ev, bit eh, int ec);
    vec_t v;
    v.rst = rst; v.stl = stl; v.fl = fl; v.sm = sm; v.st = st;
    v.in_pc4 = ip; v.in_instr = ii; v.e_pcw = ew;
    v.e_pc4 = ep; v.e_instr = ei; v.e_valid = ev; v.e_halt = eh; v.e_cnt = ec;
    return v;
  endfunction

  function automatic logic [63:0] sat(int raw, int maxv);
    return 64'((raw > maxv) ? maxv : raw);
  endfunction

  task automatic drive(bit rst, bit stl, bit fl, bit sm, bit st, logic [31:0] ip, logic [31:0] ii);
    reset = rst; stall = stl; flush = fl; smode = sm; step = st;
    pc4 = ip; pc8 = ip + 32'd4; instr = ii;
  endtask

  // Spec-level model of one clock: returns the expected PC write enable for the current inputs.
  task automatic model_apply(output bit pcw);
    bit rise, ok;
    rise = step && !m_stepq;
    ok   = !smode || m_pend || rise;
    pcw  = 1'b0;
    if (reset) begin
      m_halted = 0; m_stepq = 0; m_pend = 0; m_valid = 0; m_halt = 0;
      m_pc4 = 0; m_pc8 = 0; m_instr = 0; m_cnt = 0;
      return;
    end
    if (m_halted) begin
      m_instr = 0; m_valid = 0;
    end else if (flush) begin
      pcw = 1; m_pc4 = pc4; m_pc8 = pc8; m_instr = 0; m_valid = 0;
      m_pend = smode && (m_pend || rise);
    end else if (stall || !ok) begin
      m_pend = smode && (m_pend || rise);
    end else begin
      m_pend = 0; m_cnt++;
      m_pc4 = pc4; m_pc8 = pc8; m_instr = instr; m_valid = 1;
      if (instr == 32'hFFFF_FFFF) begin
        m_halted = 1; m_halt = 1;
      end else begin
        pcw = 1;
      end
    end
    m_stepq = step;
  endtask

  task automatic check_model();
    chk("pc4", 64'(o_pc4), 64'(m_pc4));
    chk("pc8", 64'(o_pc8), 64'(m_pc8));
    chk("instr", 64'(o_instr), 64'(m_instr));
    chk("valid", 64'(o_valid), 64'(m_valid));
    chk("halt", 64'(o_halt), 64'(m_halt));
    chk("count16", 64'(o_cnt), sat(m_cnt, 65535));
    chk("count4", 64'(s_cnt), sat(m_cnt, 15));
  endtask

  // Inputs are applied after the falling edge; PC write checked before the rising edge,
  // registered outputs checked 1 time unit after it.
  task automatic model_cycle();
    bit e_pcw;
    model_apply(e_pcw);
    #1;
    chk("pc_write", 64'(o_pcw), 64'(e_pcw));
    @(posedge clk);
    #1;
    check_model();
    @(negedge clk);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 32'd100, 32'h0);

    // directed table: rst stl fl sm st | in_pc4 in_instr | pcw exp_pc4 exp_instr valid halt cnt
    tv.push_back(mk(1,0,0,0,0, 100, 32'h0000_0000, 0,  0, 32'h0000_0000, 0, 0, 0));
    tv.push_back(mk(0,0,0,0,0,   4, 32'h2008_0005, 1,  4, 32'h2008_0005, 1, 0, 1));
    tv.push_back(mk(0,0,0,0,0,   8, 32'h2009_0003, 1,  8, 32'h2009_0003, 1, 0, 2));
    for (int k = 0; k < 3; k++)
      tv.push_back(mk(0,1,0,0,0, 12, 32'h0109_5020, 0,  8, 32'h2009_0003, 1, 0, 2));
    tv.push_back(mk(0,0,0,0,0,  12, 32'h0109_5020, 1, 12, 32'h0109_5020, 1, 0, 3));
    tv.push_back(mk(0,1,1,0,0,  16, 32'h1234_5678, 1, 16, 32'h0000_0000, 0, 0, 3));
    tv.push_back(mk(0,0,0,0,0,  20, 32'h8C0B_0000, 1, 20, 32'h8C0B_0000, 1, 0, 4));
    tv.push_back(mk(0,0,0,1,0,  24, 32'hAAAA_0001, 0, 20, 32'h8C0B_0000, 1, 0, 4));
    tv.push_back(mk(0,0,0,1,1,  24, 32'hAAAA_0001, 1, 24, 32'hAAAA_0001, 1, 0, 5));
    for (int k = 0; k < 4; k++)
      tv.push_back(mk(0,0,0,1,1, 28, 32'hBBBB_0002, 0, 24, 32'hAAAA_0001, 1, 0, 5));
    tv.push_back(mk(0,0,0,1,0,  28, 32'hBBBB_0002, 0, 24, 32'hAAAA_0001, 1, 0, 5));
    tv.push_back(mk(0,1,0,1,1,  28, 32'hBBBB_0002, 0, 24, 32'hAAAA_0001, 1, 0, 5));
    tv.push_back(mk(0,1,0,1,1,  28, 32'hBBBB_0002, 0, 24, 32'hAAAA_0001, 1, 0, 5));
    tv.push_back(mk(0,0,0,1,1,  28, 32'hBBBB_0002, 1, 28, 32'hBBBB_0002, 1, 0, 6));
    tv.push_back(mk(0,0,0,1,1,  32, 32'hCCCC_0003, 0, 28, 32'hBBBB_0002, 1, 0, 6));
    tv.push_back(mk(0,0,0,0,0,  32, 32'hFFFF_FFFF, 0, 32, 32'hFFFF_FFFF, 1, 1, 7));
    tv.push_back(mk(0,1,1,0,1,  36, 32'h0000_0123, 0, 32, 32'h0000_0000, 0, 1, 7));
    tv.push_back(mk(0,0,0,0,0,  40, 32'h0000_0001, 0, 32, 32'h0000_0000, 0, 1, 7));
    tv.push_back(mk(1,0,0,0,0,  44, 32'h0000_0001, 0,  0, 32'h0000_0000, 0, 0, 0));
    tv.push_back(mk(0,0,0,0,0,   4, 32'h3C01_0001, 1,  4, 32'h3C01_0001, 1, 0, 1));
    tv.push_back(mk(0,1,0,1,0,   8, 32'h1111_0000, 0,  4, 32'h3C01_0001, 1, 0, 1));
    tv.push_back(mk(0,1,0,1,1,   8, 32'h1111_0000, 0,  4, 32'h3C01_0001, 1, 0, 1));
    tv.push_back(mk(0,1,0,0,1,   8, 32'h1111_0000, 0,  4, 32'h3C01_0001, 1, 0, 1));
    tv.push_back(mk(0,0,0,1,1,   8, 32'h1111_0000, 0,  4, 32'h3C01_0001, 1, 0, 1));
    tv.push_back(mk(0,0,0,0,0,   8, 32'h1111_0000, 1,  8, 32'h1111_0000, 1, 0, 2));

    for (int i = 0; i < tv.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(tv[i].rst, tv[i].stl, tv[i].fl, tv[i].sm, tv[i].st, tv[i].in_pc4, tv[i].in_instr);
      #1;
      chk({tag, ".pc_write"}, 64'(o_pcw), 64'(tv[i].e_pcw));
      @(posedge clk);
      #1;
      chk({tag, ".pc4"}, 64'(o_pc4), 64'(tv[i].e_pc4));
      chk({tag, ".pc8"}, 64'(o_pc8), 64'((tv[i].e_pc4 == 0) ? 32'd0 : tv[i].e_pc4 + 32'd4));
      chk({tag, ".instr"}, 64'(o_instr), 64'(tv[i].e_instr));
      chk({tag, ".valid"}, 64'(o_valid), 64'(tv[i].e_valid));
      chk({tag, ".halt"}, 64'(o_halt), 64'(tv[i].e_halt));
      chk({tag, ".count"}, 64'(o_cnt), 64'(tv[i].e_cnt));
      @(negedge clk);
    end

    // counter saturation: 20 valid fetches
    drive(1, 0, 0, 0, 0, 32'd4, 32'h0);
    @(posedge clk); #1; @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 0, 0, 0, 32'(4 * (k + 1)), 32'h2000_0000 | 32'(k));
      @(posedge clk); #1; @(negedge clk);
    end
    chk("sat.count4", 64'(s_cnt), 64'd15);
    chk("sat.count16", 64'(o_cnt), 64'd20);
    chk("sat.valid4", 64'(s_valid), 64'd1);

    // randomized traffic against the model, starting from reset
    drive(1, 0, 0, 0, 0, 32'd4, 32'h0);
    model_cycle();
    for (int k = 0; k < 600; k++) begin
      bit rr, st, fl, sm, sp;
      logic [31:0] w;
      rr = ($urandom_range(0, 99) < 2);
      st = ($urandom_range(0, 99) < 25);
      fl = ($urandom_range(0, 99) < 12);
      sm = ($urandom_range(0, 99) < 10) ? ~smode : smode;
      sp = ($urandom_range(0, 99) < 35) ? ~step : step;
      w  = ($urandom_range(0, 99) < 3) ? 32'hFFFF_FFFF : 32'($urandom);
      drive(rr, st, fl, sm, sp, 32'($urandom) & 32'hFFFF_FFFC, w);
      model_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

IF/ID pipeline stage of the MIPS core, directly downstream of `PC`. It captures the fetched instruction together with PC+4 and PC+8 once per cycle. It turns branch/jump flushes into bubbles and honours hazard-unit stalls. It also implements debug single-step gating and HALT detection, and drives the PC write enable back upstream.

## Interface
Parameters:
- `NBITS`, 32, datapath and instruction width
- `CNTBITS`, 16, width of retired-fetch counter
- `HALT_OPCODE`, 32'hFFFF_FFFF, instruction word that ends execution
- `NOP`, 32'h0000_0000, bubble word

Ports:
- `i_clk`  in  1  clock; this block's registers update on the rising edge
- `i_reset`  in  1  synchronous, active-high reset
- `i_PC_4`  in  NBITS  PC+4 from `PC`
- `i_PC_8`  in  NBITS  PC+8 from `PC`
- `i_Instr`  in  NBITS  instruction-memory word at current PC
- `i_Stall`  in  1  hazard unit: hold IF/ID and PC
- `i_Flush`  in  1  taken branch/jump: replace fetched word with bubble
- `i_StepMode`  in  1  1 = debug single-step, 0 = free run
- `i_Step`  in  1  debug step request (level; rising edge counts)
- `o_PC_4`  out  NBITS  registered PC+4 to ID
- `o_PC_8`  out  NBITS  registered PC+8 to ID (link address)
- `o_Instr`  out  NBITS  registered instruction to ID
- `o_Valid`  out  1  o_Instr is a real instruction, not a bubble
- `o_PC_Write`  out  1  combinational enable for `PC` update
- `o_Halt`  out  1  HALT captured; fetch stopped
- `o_InstrCount`  out  CNTBITS  valid instructions captured since reset

## Operation
- FSM states are RUN and HALTED. Reset enters RUN. HALTED is left only by reset.
- Step logic:
  - `step_q` is the registered `i_Step`.
  - `step_pend` is set when `i_Step & ~step_q` in RUN with `i_StepMode`=1.
  - `step_pend` is cleared when an advance consumes it.
  - `step_ok` = `~i_StepMode | step_pend | (i_Step & ~step_q)`.
- Advance `adv` = RUN & `~i_Stall` & `step_ok`.
- Priority order in RUN, evaluated each cycle:
  1. Flush (`i_Flush`=1): capture `NOP` with `o_Valid`=0 and load `o_PC_4`/`o_PC_8` from the inputs. `o_PC_Write`=1. Flush overrides stall, step gating and HALT detection. It does not consume `step_pend`.
  2. Not `adv`: hold all outputs. `o_PC_Write`=0.
  3. `adv` with `i_Instr`==`HALT_OPCODE`: capture HALT with `o_Valid`=1, increment the counter, go to HALTED. `o_PC_Write`=0.
  4. `adv` otherwise: capture `i_Instr` with `o_Valid`=1, increment the counter. `o_PC_Write`=1.
- HALTED:
  - The cycle after entry, `o_Instr`=`NOP` and `o_Valid`=0, then hold.
  - `o_Halt`=1 and `o_PC_Write`=0.
  - Stall, flush and step are ignored.
- Counter saturates at all-ones. It never counts bubbles.
- Toggling `i_StepMode` 1→0 discards `step_pend`.

## Timing
- Capture latency is 1 cycle: rising edge N registers the values presented during cycle N-1 (PC changes on the falling edge, giving memory a half cycle).
- `o_PC_Write` is combinational from state, `i_Stall`, `i_Flush`, `i_StepMode`, `i_Step`, `step_q`, `step_pend` and `i_Instr`. It has no registered delay.
- Reset values:
  - `o_PC_4`, `o_PC_8`, `o_Instr` = 0 (`NOP`)
  - `o_Valid`, `o_Halt`, `o_InstrCount` = 0
  - `step_q`, `step_pend` = 0
  - state = RUN
- During reset, `o_PC_Write`=0.
- Reset asserted mid-stall, mid-step or in HALTED forces the reset values on the next edge.
- A step edge that coincides with `i_Stall` is held in `step_pend`. It advances exactly once on the first unstalled cycle.

## Structure
- Shared package `mips_pkg` holds `HALT_OPCODE`, `NOP` and the IF/ID FSM state encoding (RUN, HALTED); the core uses them to decode HALT in later stages.
- One sub-module, `step_ctrl`, owns `step_q`/`step_pend` and outputs `step_ok`. The stage instantiates it once.

## Test plan
- **Free run:** reset, then present `i_Instr`=0x20080005, 0x20090003 on consecutive cycles with `i_PC_4`=4, 8.
  - `o_Instr` follows one cycle later, `o_Valid`=1, `o_PC_Write`=1.
  - `o_InstrCount` reaches 2.
- **Stall 3 cycles** holding 0x01095020: outputs unchanged, `o_PC_Write`=0, counter unchanged.
  - Release: word captured once, counter +1.
- **Flush with `i_Stall`=1 simultaneously:** `o_Instr`=0, `o_Valid`=0, `o_PC_Write`=1, counter unchanged.
- **Step mode with `i_Step` held high 5 cycles:** exactly one instruction captured.
  - Step edge during stall: captured on the first cycle after stall drops.
- **`i_Instr`=0xFFFFFFFF:**
  - Captured with `o_Valid`=1; next cycle `o_Instr`=0, `o_Valid`=0.
  - `o_Halt`=1, `o_PC_Write`=0 forever.
  - `i_Reset` pulse returns all outputs to 0 and state to RUN.
- **Counter with `CNTBITS`=4:** 20 valid fetches → `o_InstrCount`=15 (saturated).
